// File: rtl/mul_div_unit_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
package MulDivTypes;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } MulDivOp;

    localparam int unsigned MULDIV_ITERATIONS = 32;
    localparam int unsigned COUNT_W           = $clog2(MULDIV_ITERATIONS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } MulDivState;

    function automatic logic [31:0] neg32(input logic [31:0] value);
        return ~value + 32'd1;
    endfunction

endpackage

// File: rtl/mul_div_unit_divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract, restore on borrow.
module DividerStep
    import MulDivTypes::*;
(
    input  logic [32:0] remainder_in,
    input  logic [31:0] quotient_in,
    input  logic [31:0] divisor,
    output logic [32:0] remainder_out,
    output logic [31:0] quotient_out
);

    logic [33:0] shifted;
    logic [33:0] diff;
    logic        borrow;

    always_comb begin
        shifted       = {remainder_in, quotient_in[31]};
        diff          = shifted - {2'b00, divisor};
        borrow        = diff[33];
        remainder_out = borrow ? shifted[32:0] : diff[32:0];
        quotient_out  = {quotient_in[30:0], ~borrow};
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add / restoring divide on magnitudes,
// with divide-by-zero and signed-overflow results short-circuited straight to DONE.
module mul_div_unit
    import MulDivTypes::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  MulDivOp     op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        clear,
    output logic        isStructureHazard,
    output logic        resultValid,
    output logic [31:0] result
);

    MulDivState         state;
    MulDivState         state_next;
    logic [COUNT_W-1:0] counter;
    logic [63:0]        product;
    logic [32:0]        remainder;
    logic [31:0]        quotient;
    logic [31:0]        operand;
    logic [31:0]        bypass_value;
    logic               bypass;
    logic               neg_result;
    logic               neg_remainder;
    MulDivOp            op_q;

    logic        a_signed;
    logic        b_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic        op_div;
    logic        div_zero;
    logic        overflow;
    logic [31:0] fast_value;
    logic        start;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] product_fixed;
    logic [32:0] step_remainder;
    logic [31:0] step_quotient;

    always_comb begin
        a_signed = op inside {MULH, MULHSU, DIV, REM};
        b_signed = op inside {MULH, DIV, REM};
        a_neg    = a_signed & srcA[31];
        b_neg    = b_signed & srcB[31];
        a_abs    = a_neg ? neg32(srcA) : srcA;
        b_abs    = b_neg ? neg32(srcB) : srcB;
        op_div   = op inside {DIV, DIVU, REM, REMU};
        div_zero = op_div && (srcB == '0);
        overflow = (op inside {DIV, REM}) && (srcA == 32'h8000_0000) && (srcB == '1);
        if (div_zero)
            fast_value = (op inside {DIV, DIVU}) ? '1 : srcA;
        else
            fast_value = (op == DIV) ? 32'h8000_0000 : '0;
        start = (state == IDLE) && req && !clear;
    end

    // Multiplier lives in the low half of the product and is consumed as the sum shifts in.
    always_comb begin
        mul_sum  = {1'b0, product[63:32]} + {1'b0, operand};
        mul_next = product[0] ? {mul_sum, product[31:1]} : {1'b0, product[63:1]};
    end

    DividerStep u_divider_step (
        .remainder_in  (remainder),
        .quotient_in   (quotient),
        .divisor       (operand),
        .remainder_out (step_remainder),
        .quotient_out  (step_quotient)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req) state_next = (div_zero || overflow) ? DONE : CALC;
            CALC: if (counter == '0) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter       <= '0;
            product       <= '0;
            remainder     <= '0;
            quotient      <= '0;
            operand       <= '0;
            bypass_value  <= '0;
            bypass        <= 1'b0;
            neg_result    <= 1'b0;
            neg_remainder <= 1'b0;
            op_q          <= MUL;
        end else if (start) begin
            counter       <= COUNT_W'(MULDIV_ITERATIONS - 1);
            product       <= {32'd0, b_abs};
            remainder     <= '0;
            quotient      <= a_abs;
            operand       <= op_div ? b_abs : a_abs;
            bypass_value  <= fast_value;
            bypass        <= div_zero || overflow;
            neg_result    <= a_neg ^ b_neg;
            neg_remainder <= a_neg;
            op_q          <= op;
        end else if (state == CALC && !clear) begin
            counter <= counter - 1'b1;
            if (op_q inside {DIV, DIVU, REM, REMU}) begin
                remainder <= step_remainder;
                quotient  <= step_quotient;
            end else begin
                product <= mul_next;
            end
        end
    end

    always_comb begin
        isStructureHazard = req && (state != DONE) && !clear && !rst;
        resultValid       = (state == DONE);
        product_fixed     = neg_result ? (~product + 64'd1) : product;
        result            = '0;
        if (state == DONE) begin
            if (bypass) begin
                result = bypass_value;
            end else begin
                case (op_q)
                    MUL:                 result = product[31:0];
                    MULH, MULHSU, MULHU: result = product_fixed[63:32];
                    DIV, DIVU:           result = neg_result ? neg32(quotient) : quotient;
                    REM, REMU:           result = neg_remainder ? neg32(remainder[31:0]) : remainder[31:0];
                    default:             result = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit; each task owns its stimulus and comparisons.
module tb_mul_div_unit;
    import MulDivTypes::*;

    logic        clk;
    logic        rst;
    logic        req;
    MulDivOp     op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        clear;
    logic        isStructureHazard;
    logic        resultValid;
    logic [31:0] result;

    int checks;
    int errors;

    mul_div_unit dut (
        .clk               (clk),
        .rst               (rst),
        .req               (req),
        .op                (op),
        .srcA              (srcA),
        .srcB              (srcB),
        .clear             (clear),
        .isStructureHazard (isStructureHazard),
        .resultValid       (resultValid),
        .result            (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one operation with req held until resultValid, then drops req for one cycle.
    task automatic run_op(input MulDivOp o, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res, output bit haz_busy,
                          output logic haz_done, output bit timeout,
                          output logic v_after, output logic [31:0] r_after);
        req = 1'b1; op = o; srcA = a; srcB = b;
        lat = 0; haz_busy = 1'b1; timeout = 1'b0;
        #1;
        while (resultValid !== 1'b1) begin
            if (isStructureHazard !== 1'b1) haz_busy = 1'b0;
            if (lat >= 40) begin
                timeout = 1'b1;
                break;
            end
            step();
            lat++;
        end
        res      = result;
        haz_done = isStructureHazard;
        req = 1'b0;
        step();
        v_after = resultValid;
        r_after = result;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0; clear = 1'b0; op = MUL; srcA = 32'd7; srcB = 32'd6;
        repeat (3) @(posedge clk);
        #1;
        req = 1'b1;
        #1;
        checks++; if (isStructureHazard !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b want 0", isStructureHazard); end
        checks++; if (resultValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", resultValid); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        req = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic test_mul();
        int lat; logic [31:0] res; bit hb; logic hd; bit to; logic va; logic [31:0] ra;
        run_op(MUL, 32'd7, 32'd6, lat, res, hb, hd, to, va, ra);
        checks++; if (to) begin errors++; $display("FAIL mul_timeout got no resultValid within 40 cycles"); end
        checks++; if (lat != 33) begin errors++; $display("FAIL mul_latency got %0d want 33", lat); end
        checks++; if (res !== 32'd42) begin errors++; $display("FAIL mul_result got %h want 0000002a", res); end
        checks++; if (!hb) begin errors++; $display("FAIL mul_hazard_busy got low before cycle 33 want high"); end
        checks++; if (hd !== 1'b0) begin errors++; $display("FAIL mul_hazard_done got %b want 0", hd); end
        checks++; if (va !== 1'b0) begin errors++; $display("FAIL mul_valid_after got %b want 0", va); end
        checks++; if (ra !== 32'd0) begin errors++; $display("FAIL mul_result_after got %h want 0", ra); end
    endtask

    task automatic test_mul_high();
        MulDivOp     ops [3] = '{MULH, MULHSU, MULHU};
        logic [31:0] as  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [3] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        int lat; logic [31:0] res; bit hb; logic hd; bit to; logic va; logic [31:0] ra;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], as[i], bs[i], lat, res, hb, hd, to, va, ra);
            checks++; if (res !== exp[i] || lat != 33) begin errors++; $display("FAIL mulh_%0d got %h lat %0d want %h lat 33", i, res, lat, exp[i]); end
        end
    endtask

    task automatic test_divide();
        MulDivOp     ops [4] = '{DIV, REM, DIVU, REMU};
        logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        int lat; logic [31:0] res; bit hb; logic hd; bit to; logic va; logic [31:0] ra;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], lat, res, hb, hd, to, va, ra);
            checks++; if (res !== exp[i] || lat != 33) begin errors++; $display("FAIL div_%0d got %h lat %0d want %h lat 33", i, res, lat, exp[i]); end
        end
    endtask

    task automatic test_fast_path();
        MulDivOp     ops [4] = '{DIV, REM, DIV, DIVU};
        logic [31:0] as  [4] = '{32'd1234, 32'd5, 32'h8000_0000, 32'hDEAD_BEEF};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF};
        int lat; logic [31:0] res; bit hb; logic hd; bit to; logic va; logic [31:0] ra;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], lat, res, hb, hd, to, va, ra);
            checks++; if (res !== exp[i] || lat != 1) begin errors++; $display("FAIL fast_%0d got %h lat %0d want %h lat 1", i, res, lat, exp[i]); end
        end
        run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, hb, hd, to, va, ra);
        checks++; if (res !== 32'd0 || lat != 1) begin errors++; $display("FAIL fast_rem_ovf got %h lat %0d want 0 lat 1", res, lat); end
    endtask

    task automatic test_clear();
        int seen;
        int lat; logic [31:0] res; bit hb; logic hd; bit to; logic va; logic [31:0] ra;
        req = 1'b1; op = DIV; srcA = 32'd100; srcB = 32'd7;
        repeat (10) step();
        clear = 1'b1;
        #1;
        checks++; if (isStructureHazard !== 1'b0) begin errors++; $display("FAIL clear_hazard got %b want 0", isStructureHazard); end
        step();
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL clear_state got %0d want IDLE", dut.state); end
        clear = 1'b0; req = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (resultValid === 1'b1) seen++;
            step();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL clear_no_valid got %0d valid cycles want 0", seen); end
        run_op(MUL, 32'd3, 32'd3, lat, res, hb, hd, to, va, ra);
        checks++; if (res !== 32'd9 || lat != 33) begin errors++; $display("FAIL clear_then_mul got %h lat %0d want 9 lat 33", res, lat); end
    endtask

    task automatic test_reset_mid_op();
        int lat; logic [31:0] res; bit hb; logic hd; bit to; logic va; logic [31:0] ra;
        req = 1'b1; op = MUL; srcA = 32'd7; srcB = 32'd6;
        repeat (5) step();
        rst = 1'b1;
        #1;
        checks++; if (isStructureHazard !== 1'b0 || resultValid !== 1'b0 || result !== 32'd0)
            begin errors++; $display("FAIL rst_outputs got haz %b valid %b result %h want 0 0 0", isStructureHazard, resultValid, result); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rst_state got %0d want IDLE", dut.state); end
        req = 1'b0;
        step();
        rst = 1'b0;
        step();
        run_op(DIVU, 32'd9, 32'd3, lat, res, hb, hd, to, va, ra);
        checks++; if (res !== 32'd3 || lat != 33) begin errors++; $display("FAIL rst_then_divu got %h lat %0d want 3 lat 33", res, lat); end
    endtask

    task automatic test_operand_change();
        int lat;
        req = 1'b1; op = MUL; srcA = 32'd7; srcB = 32'd6;
        lat = 0;
        #1;
        while (resultValid !== 1'b1 && lat < 40) begin
            step();
            lat++;
            if (lat == 5) begin op = DIV; srcA = 32'd100; srcB = 32'd3; end
        end
        checks++; if (result !== 32'd42 || lat != 33) begin errors++; $display("FAIL operand_change got %h lat %0d want 2a lat 33", result, lat); end
        req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] res; bit hb; logic hd; bit to; logic va; logic [31:0] ra;
        run_op(DIVU, 32'hFFFF_FFFF, 32'd16, lat, res, hb, hd, to, va, ra);
        checks++; if (res !== 32'h0FFF_FFFF || lat != 33) begin errors++; $display("FAIL b2b_first got %h lat %0d want 0fffffff lat 33", res, lat); end
        run_op(REM, 32'd7, 32'hFFFF_FFFE, lat, res, hb, hd, to, va, ra);
        checks++; if (res !== 32'd1 || lat != 33) begin errors++; $display("FAIL b2b_second got %h lat %0d want 1 lat 33", res, lat); end
        run_op(MUL, 32'hFFFF_FFFD, 32'd5, lat, res, hb, hd, to, va, ra);
        checks++; if (res !== 32'hFFFF_FFF1 || lat != 33) begin errors++; $display("FAIL b2b_third got %h lat %0d want fffffff1 lat 33", res, lat); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_mul();
        test_mul_high();
        test_divide();
        test_fast_path();
        test_clear();
        test_reset_mid_op();
        test_operand_change();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: MulDivUnit

Interface
REQ-001 The block SHALL have ports clk, rst, req, op, srcA, srcB, clear, isStructureHazard, resultValid and result, and no others.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req  in  1  execute stage holds an M-extension instruction; held high until resultValid.
REQ-005 op  in  3  MulDivOp: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; stable while req is high.
REQ-006 srcA  in  32  rs1 operand; stable while req is high.
REQ-007 srcB  in  32  rs2 operand; stable while req is high.
REQ-008 clear  in  1  mulDivClear from the stage controller; aborts the operation.
REQ-009 isStructureHazard  out  1  stall request to the stage controller.
REQ-010 resultValid  out  1  result is valid this cycle.
REQ-011 result  out  32  RV32M result.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 IDLE: if req && !clear, the block SHALL latch abs/raw operands, sign flags and op, load the iteration counter with 31, and go to CALC.
REQ-014 IDLE, divide by zero: the block SHALL skip CALC and go straight to DONE with DIV/DIVU = 0xFFFFFFFF and REM/REMU = srcA.
REQ-015 IDLE, signed overflow (DIV/REM, srcA=0x80000000, srcB=0xFFFFFFFF): the block SHALL go straight to DONE with DIV = 0x80000000 and REM = 0.
REQ-016 CALC, multiply: the block SHALL do one radix-2 shift-add step per cycle on magnitudes into a 64-bit product register.
REQ-017 CALC, divide: the block SHALL do one restoring step per cycle (33-bit partial remainder, 32-bit quotient) on magnitudes.
REQ-018 CALC: the counter SHALL decrement each cycle, and CALC SHALL go to DONE in the cycle the counter is 0, giving 32 CALC cycles.
REQ-019 DONE: the block SHALL hold resultValid=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-020 Normal latency: with req first high in cycle 0 (IDLE), resultValid SHALL be high in cycle 33.
REQ-021 Fast-path latency (div-by-0, overflow): resultValid SHALL be high in cycle 1.
REQ-022 Sign fixup SHALL be applied on the DONE output only:
  - negate the product if the operand signs differ (MULH; MULHSU uses srcB as unsigned);
  - negate the quotient if the signs differ;
  - the remainder takes the sign of the dividend.
REQ-023 MUL SHALL output product[31:0]; MULH, MULHSU and MULHU SHALL output product[63:32].
REQ-024 isStructureHazard SHALL equal req && state!=DONE && !clear, combinationally.
REQ-025 result SHALL be 0 whenever resultValid=0.
REQ-026 clear in any state SHALL move the FSM to IDLE on the next edge, with no resultValid; clear SHALL override a simultaneous req.
REQ-027 A req arriving in the DONE cycle SHALL be treated as the completing instruction; a new operation SHALL be accepted only from IDLE, so back-to-back operations have a one-cycle gap.
REQ-028 Operand or op changes while in CALC SHALL be ignored; only the latched values SHALL be used.

Reset
REQ-029 rst SHALL force IDLE, counter=0, product/remainder/quotient registers=0, resultValid=0 and result=0 asynchronously.
REQ-030 isStructureHazard SHALL be 0 while rst is high.
REQ-031 rst asserted mid-CALC SHALL abandon the operation; after release, the first req SHALL start from IDLE.

Structure
REQ-032 Package MulDivTypes SHALL hold the MulDivOp enum, MULDIV_ITERATIONS=32 and the MulDivState enum; these SHALL NOT be redeclared locally.
REQ-033 The per-cycle divide step (33-bit subtract/restore, quotient shift) SHALL be a sub-module, DividerStep; the multiply step SHALL stay inline.
REQ-034 No multiplier primitive (*) and no divide operator SHALL be used.

Verification
REQ-035 MUL 7 x 6 (req held):
  - isStructureHazard SHALL be high in cycles 0-32;
  - resultValid and result=42 SHALL appear in cycle 33;
  - isStructureHazard SHALL be low in cycle 33.
REQ-036 MULH 0x80000000 x 0x80000000 SHALL give 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF SHALL give 0xFFFFFFFF; MULHU of the same operands SHALL give 0xFFFFFFFE.
REQ-037 DIV -7/2 SHALL give 0xFFFFFFFD; REM -7/2 SHALL give 0xFFFFFFFF; DIVU 100/7 SHALL give 14; REMU 100/7 SHALL give 2.
REQ-038 DIV x/0 SHALL give 0xFFFFFFFF in cycle 1; REM 5/0 SHALL give 5; DIV 0x80000000/-1 SHALL give 0x80000000 in cycle 1.
REQ-039 Clear at cycle 10 of a DIV:
  - isStructureHazard SHALL be low in cycle 10;
  - the FSM SHALL be IDLE in cycle 11;
  - no resultValid SHALL occur;
  - a new MUL 3x3 SHALL give 9, 33 cycles after its req.
REQ-040 rst pulsed at cycle 5 of a MUL SHALL force all outputs to 0 immediately, and a following DIVU 9/3 SHALL give 3.
